fam_wb_merge: RTL and testbench

Floating-point writeback merge stage between the FAM result port and the FPU register file / FCSR. It accepts FAM results through a valid/yumi handshake into a small skid buffer and merges them with the in-order FPI writeback stream onto the single FRF write port. It accumulates exception flags from both sources into the FCSR (frm + fflags) and raises a stall to FPI when a buffered FAM result is starved.

---
 rtl/fam_wb_merge.sv | 201 ++++++++++++++++++++
 tb/tb_fam_wb_merge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fam_wb_merge.sv
// FP writeback merge: FAM results (skid FIFO) + in-order FPI writeback onto one FRF port; FCSR accrual.
// Latency: FAM result accepted at t is written to the FRF at t+1 at the earliest (t with FAM_WB_BYPASS_EN).
// Backpressure: fam_yumi_o drops while the FIFO is full; a starved FIFO head raises fpi_stall_o for one cycle.
// Optional feature: define FAM_WB_BYPASS_EN for a zero-latency FAM path when the FIFO is empty and the port is idle.
module fam_wb_merge #(
    parameter int BUF_ELS      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        fpi_v_i,
    input  logic        fpi_writes_frf_i,
    input  logic        fpi_writes_fflags_i,
    input  logic [4:0]  fpi_fflags_i,
    input  logic [4:0]  fpi_frd_addr_i,
    input  logic [31:0] fpi_data_i,
    output logic        fpi_stall_o,

    input  logic        fam_v_i,
    input  logic [31:0] fam_data_i,
    input  logic [4:0]  fam_fflags_i,
    input  logic [4:0]  fam_frd_addr_i,
    output logic        fam_yumi_o,

    output logic        frf_w_v_o,
    output logic [4:0]  frf_w_addr_o,
    output logic [31:0] frf_w_data_o,

    input  logic        csr_w_v_i,
    input  logic [7:0]  csr_w_data_i,
    output logic [7:0]  fcsr_o
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  fflags;
        logic [4:0]  addr;
    } entry_t;

    localparam int PTR_W = (BUF_ELS > 1) ? $clog2(BUF_ELS) : 1;
    localparam int CNT_W = $clog2(BUF_ELS + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_ELS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_ELS);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

    // FIFO storage and pointers
    entry_t           mem_q [BUF_ELS];
    entry_t           mem_d [BUF_ELS];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // starvation tracking
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;

    // FCSR
    logic [2:0]       frm_q, frm_d;
    logic [4:0]       fflags_q, fflags_d;

    // datapath decisions for the current cycle
    logic             buf_empty;
    logic             buf_full;
    logic             fpi_accept;
    logic             fpi_frf_wr;
    logic             fpi_flag_wr;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             yumi;
    entry_t           head;
    entry_t           fam_entry;
    logic [4:0]       fam_wr_flags;

    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == FULL_CNT);
    assign head      = mem_q[rd_ptr_q];
    assign fam_entry = '{data: fam_data_i, fflags: fam_fflags_i, addr: fam_frd_addr_i};

    // FPI is ignored entirely while the stall is up; upstream holds its entry.
    assign fpi_accept  = fpi_v_i & ~stall_q;
    assign fpi_frf_wr  = fpi_accept & fpi_writes_frf_i;
    assign fpi_flag_wr = fpi_accept & fpi_writes_fflags_i;

    // The head drains whenever FPI leaves the port free (always so during a stall).
    assign pop = ~buf_empty & ~fpi_frf_wr;

`ifdef FAM_WB_BYPASS_EN
    assign bypass = buf_empty & ~fpi_frf_wr & fam_v_i;
`else
    assign bypass = 1'b0;
`endif

    // No push-on-pop: a full FIFO refuses the new result even if the head drains.
    assign yumi = fam_v_i & ~buf_full & ~reset_i;
    assign push = yumi & ~bypass;

    assign fam_yumi_o  = yumi;
    assign fpi_stall_o = stall_q;
    assign fcsr_o      = {frm_q, fflags_q};

    // FRF write port mux: FPI first, then FIFO head, then bypassed FAM result
    always_comb begin
        frf_w_v_o    = 1'b0;
        frf_w_addr_o = '0;
        frf_w_data_o = '0;
        fam_wr_flags = '0;
        if (!reset_i) begin
            if (fpi_frf_wr) begin
                frf_w_v_o    = 1'b1;
                frf_w_addr_o = fpi_frd_addr_i;
                frf_w_data_o = fpi_data_i;
            end else if (pop) begin
                frf_w_v_o    = 1'b1;
                frf_w_addr_o = head.addr;
                frf_w_data_o = head.data;
                fam_wr_flags = head.fflags;
            end else if (bypass) begin
                frf_w_v_o    = 1'b1;
                frf_w_addr_o = fam_entry.addr;
                frf_w_data_o = fam_entry.data;
                fam_wr_flags = fam_entry.fflags;
            end
        end
    end

    // FIFO next state: write at tail on push, advance head on pop, track occupancy
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = fam_entry;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: counts cycles the head sits undrained; the stall flop
    // rises the cycle after the count reaches the limit and forces a drain.
    always_comb begin
        starve_d = starve_q;
        if (pop || buf_empty) begin
            starve_d = '0;
        end else if (starve_q != STV_LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d == STV_LIMIT);
    end

    // FCSR: CSR write replaces the base value, flags written this cycle OR on top
    always_comb begin
        frm_d    = frm_q;
        fflags_d = fflags_q;
        if (csr_w_v_i) begin
            frm_d    = csr_w_data_i[7:5];
            fflags_d = csr_w_data_i[4:0];
        end
        if (fpi_flag_wr) begin
            fflags_d = fflags_d | fpi_fflags_i;
        end
        fflags_d = fflags_d | fam_wr_flags;
    end

    // State registers with synchronous reset; reset discards buffered results
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < BUF_ELS; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            frm_q    <= '0;
            fflags_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
        end
    end

endmodule

// File: tb/tb_fam_wb_merge.sv
// Bench for fam_wb_merge: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_fam_wb_merge;

    localparam int BUF_ELS      = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  fflags;
        logic [4:0]  addr;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fpi_v_i, fpi_writes_frf_i, fpi_writes_fflags_i;
    logic [4:0]  fpi_fflags_i, fpi_frd_addr_i;
    logic [31:0] fpi_data_i;
    logic        fpi_stall_o;
    logic        fam_v_i;
    logic [31:0] fam_data_i;
    logic [4:0]  fam_fflags_i, fam_frd_addr_i;
    logic        fam_yumi_o;
    logic        frf_w_v_o;
    logic [4:0]  frf_w_addr_o;
    logic [31:0] frf_w_data_o;
    logic        csr_w_v_i;
    logic [7:0]  csr_w_data_i;
    logic [7:0]  fcsr_o;

    int checks   = 0;
    int failures = 0;

    // reference model state
    ent_t        mq[$];
    int          m_starve;
    bit          m_stall;
    logic [2:0]  m_frm;
    logic [4:0]  m_ff;

    always #5 clk_i = ~clk_i;

    fam_wb_merge #(.BUF_ELS(BUF_ELS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .fpi_v_i             (fpi_v_i),
        .fpi_writes_frf_i    (fpi_writes_frf_i),
        .fpi_writes_fflags_i (fpi_writes_fflags_i),
        .fpi_fflags_i        (fpi_fflags_i),
        .fpi_frd_addr_i      (fpi_frd_addr_i),
        .fpi_data_i          (fpi_data_i),
        .fpi_stall_o         (fpi_stall_o),
        .fam_v_i             (fam_v_i),
        .fam_data_i          (fam_data_i),
        .fam_fflags_i        (fam_fflags_i),
        .fam_frd_addr_i      (fam_frd_addr_i),
        .fam_yumi_o          (fam_yumi_o),
        .frf_w_v_o           (frf_w_v_o),
        .frf_w_addr_o        (frf_w_addr_o),
        .frf_w_data_o        (frf_w_data_o),
        .csr_w_v_i           (csr_w_v_i),
        .csr_w_data_i        (csr_w_data_i),
        .fcsr_o              (fcsr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        fpi_v_i             = 1'b0;
        fpi_writes_frf_i    = 1'b0;
        fpi_writes_fflags_i = 1'b0;
        fpi_fflags_i        = '0;
        fpi_frd_addr_i      = '0;
        fpi_data_i          = '0;
        fam_v_i             = 1'b0;
        fam_data_i          = '0;
        fam_fflags_i        = '0;
        fam_frd_addr_i      = '0;
        csr_w_v_i           = 1'b0;
        csr_w_data_i        = '0;
    endtask

    task automatic fpi_busy(input logic [4:0] a, input logic [31:0] d);
        fpi_v_i          = 1'b1;
        fpi_writes_frf_i = 1'b1;
        fpi_frd_addr_i   = a;
        fpi_data_i       = d;
    endtask

    task automatic fam_send(input logic [4:0] a, input logic [31:0] d, input logic [4:0] f);
        fam_v_i        = 1'b1;
        fam_frd_addr_i = a;
        fam_data_i     = d;
        fam_fflags_i   = f;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle();
        fam_send(5'd30, 32'hDEADBEEF, 5'h1F);
        @(posedge clk_i); #1;
        chk("rst_stall", fpi_stall_o, 1'b0);
        chk("rst_fcsr", fcsr_o, 8'h00);
        chk("rst_yumi", fam_yumi_o, 1'b0);
        chk("rst_frf_v", frf_w_v_o, 1'b0);
        chk("rst_frf_addr", frf_w_addr_o, 5'd0);
        chk("rst_frf_data", frf_w_data_o, 32'd0);
        reset_i = 1'b0;
        idle();
        mq.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_frm    = '0;
        m_ff     = '0;
    endtask

    // one clock: compare outputs with the model, then advance the model
    task automatic cycle();
        bit         fpi_ok, fpi_frf, yumi, byp, popped, ev;
        logic [4:0] ea, fl, ff_new;
        logic [31:0] ed;
        @(negedge clk_i);
        fpi_ok  = fpi_v_i && !m_stall;
        fpi_frf = fpi_ok && fpi_writes_frf_i;
        yumi    = fam_v_i && (mq.size() < BUF_ELS);
        byp     = 1'b0;
`ifdef FAM_WB_BYPASS_EN
        byp     = (mq.size() == 0) && !fpi_frf && fam_v_i;
`endif
        popped = 1'b0; ev = 1'b0; ea = '0; ed = '0; fl = '0;
        if (fpi_frf) begin
            ev = 1'b1; ea = fpi_frd_addr_i; ed = fpi_data_i;
        end else if (mq.size() > 0) begin
            ev = 1'b1; ea = mq[0].addr; ed = mq[0].data; fl = mq[0].fflags; popped = 1'b1;
        end else if (byp) begin
            ev = 1'b1; ea = fam_frd_addr_i; ed = fam_data_i; fl = fam_fflags_i;
        end
        ff_new = (csr_w_v_i ? csr_w_data_i[4:0] : m_ff) | fl;
        if (fpi_ok && fpi_writes_fflags_i) ff_new = ff_new | fpi_fflags_i;

        chk("frf_v", frf_w_v_o, ev);
        chk("frf_addr", frf_w_addr_o, ea);
        chk("frf_data", frf_w_data_o, ed);
        chk("yumi", fam_yumi_o, yumi);
        chk("stall", fpi_stall_o, m_stall);
        chk("fcsr", fcsr_o, {m_frm, m_ff});

        m_starve = (popped || mq.size() == 0) ? 0 : m_starve + 1;
        m_stall  = (m_starve == STARVE_LIMIT);
        if (popped) void'(mq.pop_front());
        if (yumi && !byp) mq.push_back('{data: fam_data_i, fflags: fam_fflags_i, addr: fam_frd_addr_i});
        m_ff = ff_new;
        if (csr_w_v_i) m_frm = csr_w_data_i[7:5];
        @(posedge clk_i); #1;
    endtask

    initial begin
        reset_i = 1'b0;
        idle();
        @(posedge clk_i); #1;
        do_reset();

        // single FAM result, no FPI traffic
        fam_send(5'd3, 32'h3F800000, 5'h00);
        #1;
        chk("t1_yumi", fam_yumi_o, 1'b1);
`ifdef FAM_WB_BYPASS_EN
        chk("t1_frf_v_t", frf_w_v_o, 1'b1);
        chk("t1_frf_data_t", frf_w_data_o, 32'h3F800000);
        cycle();
        idle();
`else
        chk("t1_frf_v_t", frf_w_v_o, 1'b0);
        cycle();
        idle(); #1;
        chk("t1_frf_v_t1", frf_w_v_o, 1'b1);
        chk("t1_frf_addr_t1", frf_w_addr_o, 5'd3);
        chk("t1_frf_data_t1", frf_w_data_o, 32'h3F800000);
        cycle();
`endif
        chk("t1_fcsr", fcsr_o, 8'h00);

        // FPI f1 and FAM f2 in the same cycle
        fpi_busy(5'd1, 32'h40000000);
        fam_send(5'd2, 32'h12345678, 5'h00);
        #1;
        chk("t2_first_addr", frf_w_addr_o, 5'd1);
        cycle();
        idle(); #1;
        chk("t2_second_addr", frf_w_addr_o, 5'd2);
        chk("t2_second_data", frf_w_data_o, 32'h12345678);
        cycle(); #1;
        chk("t2_no_repeat", frf_w_v_o, 1'b0);

        // starvation: FPI writes every cycle, one FAM entry buffered
        fpi_busy(5'd7, 32'h11111111);
        fam_send(5'd9, 32'hAAAA5555, 5'h00);
        cycle();
        fam_v_i = 1'b0;
        for (int i = 1; i <= STARVE_LIMIT; i++) begin
            chk("t3_no_stall", fpi_stall_o, 1'b0);
            cycle();
        end
        chk("t3_stall", fpi_stall_o, 1'b1);
        chk("t3_head_addr", frf_w_addr_o, 5'd9);
        cycle();
        chk("t3_stall_clear", fpi_stall_o, 1'b0);
        chk("t3_fpi_back", frf_w_addr_o, 5'd7);

        // three back-to-back FAM results with FPI busy
        for (int i = 0; i < 3; i++) begin
            fam_send(5'(10 + i), 32'(32'h100 + i), 5'h00);
            #1;
            chk("t4_yumi", fam_yumi_o, (i < 2) ? 1'b1 : 1'b0);
            if (i < 2) cycle();
        end
        fpi_v_i = 1'b0; #1;
        chk("t4_full_pop_yumi", fam_yumi_o, 1'b0);
        chk("t4_pop_addr", frf_w_addr_o, 5'd10);
        cycle(); #1;
        chk("t4_third_yumi", fam_yumi_o, 1'b1);
        cycle();
        idle();
        repeat (3) cycle();

        // FPI NX and drained FAM DZ in the same cycle
        do_reset();
        fpi_busy(5'd5, 32'h0);
        fam_send(5'd4, 32'h7F800000, 5'b01000);
        cycle();
        idle();
        fpi_v_i = 1'b1; fpi_writes_fflags_i = 1'b1; fpi_fflags_i = 5'b00001;
        #1;
        chk("t5_drain_addr", frf_w_addr_o, 5'd4);
        cycle();
        chk("t5_fflags", fcsr_o[4:0], 5'b01001);

        // CSR write with NV accrual in the same cycle
        idle();
        csr_w_v_i = 1'b1; csr_w_data_i = 8'hE0;
        fpi_v_i = 1'b1; fpi_writes_fflags_i = 1'b1; fpi_fflags_i = 5'b10000;
        cycle();
        chk("t6_fcsr", fcsr_o, 8'hF0);

        // reset with a full buffer
        idle();
        fpi_busy(5'd6, 32'h6);
        fam_send(5'd20, 32'h20, 5'h04);
        cycle();
        fam_send(5'd21, 32'h21, 5'h02);
        cycle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_no_write", frf_w_v_o, 1'b0);
            cycle();
        end

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int pct;
            pct = ((n / 250) % 2 == 1) ? 95 : 40;
            fpi_v_i             = ($urandom_range(0, 99) < pct);
            fpi_writes_frf_i    = ($urandom_range(0, 3) != 0);
            fpi_writes_fflags_i = $urandom_range(0, 1) == 1;
            fpi_fflags_i        = 5'($urandom);
            fpi_frd_addr_i      = 5'($urandom);
            fpi_data_i          = $urandom;
            fam_v_i             = $urandom_range(0, 1) == 1;
            fam_data_i          = $urandom;
            fam_fflags_i        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
            fam_frd_addr_i      = 5'($urandom);
            csr_w_v_i           = ($urandom_range(0, 15) == 0);
            csr_w_data_i        = 8'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
